// File: rtl/updi_cs_access.sv
// UPDI LDCS/STCS sequencer: pushes SYNCH/opcode/data to the PHY, consumes echoes and load response.
// Optional macro UPDI_ECHO_CHECK_EN enables echo-vs-sent byte comparison (err_code 3).
module updi_cs_access #(
    parameter int unsigned TIMEOUT_CLK = 200000,
    parameter logic [7:0]  SYNCH_BYTE  = 8'h55
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       req_store,
    input  logic [3:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic [1:0] err_code,
    output logic [7:0] uart_tx_fifo_data,
    output logic       uart_tx_fifo_wr_en,
    input  logic       uart_tx_fifo_full,
    input  logic [7:0] uart_rx_fifo_data,
    output logic       uart_rx_fifo_rd_en,
    input  logic       uart_rx_fifo_empty,
    input  logic       rx_error,
    output logic       double_break_start,
    input  logic       double_break_busy,
    input  logic       double_break_done
);

    localparam int unsigned TW = $clog2(TIMEOUT_CLK + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CLK);

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_RX      = 2'd2;
    localparam logic [1:0] ERR_ECHO    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX,
        S_ECHO,
        S_RESP,
        S_BRK_START,
        S_BRK_WAIT,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic          is_store;
    logic [3:0]    addr_q;
    logic [7:0]    wdata_q;
    logic [1:0]    tx_idx, tx_idx_nxt;
    logic [1:0]    echo_cnt, echo_cnt_nxt;
    logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
    logic [TW-1:0] tmo_inc;
    logic [7:0]    rdata_nxt;
    logic [1:0]    err_nxt;
    logic [7:0]    opcode;
    logic [1:0]    byte_cnt;
    logic [1:0]    last_idx;
    logic          echo_mismatch;

    function automatic logic [7:0] byte_at(input logic [1:0] idx,
                                           input logic [7:0] op,
                                           input logic [7:0] wd);
        case (idx)
            2'd0:    byte_at = SYNCH_BYTE;
            2'd1:    byte_at = op;
            default: byte_at = wd;
        endcase
    endfunction

    assign opcode   = {(is_store ? 4'hC : 4'h8), addr_q};
    assign byte_cnt = is_store ? 2'd3 : 2'd2;
    assign last_idx = is_store ? 2'd2 : 2'd1;
    assign tmo_inc  = tmo_cnt + 1'b1;

`ifdef UPDI_ECHO_CHECK_EN
    logic [1:0] echo_idx;
    // Echoes return in send order, so the expected byte index is (sent - remaining).
    assign echo_idx      = byte_cnt - echo_cnt;
    assign echo_mismatch = (uart_rx_fifo_data != byte_at(echo_idx, opcode, wdata_q));
`else
    assign echo_mismatch = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only; all next values come from always_comb.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            tx_idx   <= 2'd0;
            echo_cnt <= 2'd0;
            tmo_cnt  <= '0;
            rdata    <= 8'h00;
            err_code <= ERR_NONE;
            is_store <= 1'b0;
            addr_q   <= 4'h0;
            wdata_q  <= 8'h00;
        end else begin
            state    <= state_nxt;
            tx_idx   <= tx_idx_nxt;
            echo_cnt <= echo_cnt_nxt;
            tmo_cnt  <= tmo_cnt_nxt;
            rdata    <= rdata_nxt;
            err_code <= err_nxt;
            if (state == S_IDLE && req) begin
                is_store <= req_store;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt          = state;
        tx_idx_nxt         = tx_idx;
        echo_cnt_nxt       = echo_cnt;
        tmo_cnt_nxt        = tmo_cnt;
        rdata_nxt          = rdata;
        err_nxt            = err_code;
        uart_tx_fifo_data  = byte_at(tx_idx, opcode, wdata_q);
        uart_tx_fifo_wr_en = 1'b0;
        uart_rx_fifo_rd_en = 1'b0;
        double_break_start = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (req) begin
                    err_nxt    = ERR_NONE;
                    tx_idx_nxt = 2'd0;
                    state_nxt  = S_TX;
                end
            end

            S_TX: begin
                if (!uart_tx_fifo_full) begin
                    uart_tx_fifo_wr_en = 1'b1;
                    if (tx_idx == last_idx) begin
                        echo_cnt_nxt = byte_cnt;
                        tmo_cnt_nxt  = '0;
                        state_nxt    = S_ECHO;
                    end else begin
                        tx_idx_nxt = tx_idx + 2'd1;
                    end
                end
            end

            S_ECHO: begin
                // Priority within a cycle: rx_error, then echo mismatch, then timeout.
                if (rx_error) begin
                    err_nxt   = ERR_RX;
                    state_nxt = S_BRK_START;
                end else if (!uart_rx_fifo_empty) begin
                    uart_rx_fifo_rd_en = 1'b1;
                    tmo_cnt_nxt        = '0;
                    if (echo_mismatch) begin
                        err_nxt   = ERR_ECHO;
                        state_nxt = S_BRK_START;
                    end else begin
                        echo_cnt_nxt = echo_cnt - 2'd1;
                        if (echo_cnt == 2'd1)
                            state_nxt = is_store ? S_DONE : S_RESP;
                    end
                end else begin
                    tmo_cnt_nxt = tmo_inc;
                    if (tmo_inc == TMO_LIMIT) begin
                        err_nxt   = ERR_TIMEOUT;
                        state_nxt = S_BRK_START;
                    end
                end
            end

            S_RESP: begin
                if (rx_error) begin
                    err_nxt   = ERR_RX;
                    state_nxt = S_BRK_START;
                end else if (!uart_rx_fifo_empty) begin
                    uart_rx_fifo_rd_en = 1'b1;
                    tmo_cnt_nxt        = '0;
                    rdata_nxt          = uart_rx_fifo_data;
                    state_nxt          = S_DONE;
                end else begin
                    tmo_cnt_nxt = tmo_inc;
                    if (tmo_inc == TMO_LIMIT) begin
                        err_nxt   = ERR_TIMEOUT;
                        state_nxt = S_BRK_START;
                    end
                end
            end

            S_BRK_START: begin
                // A break already running is joined rather than restarted.
                if (double_break_busy) begin
                    state_nxt = double_break_done ? S_FLUSH : S_BRK_WAIT;
                end else begin
                    double_break_start = 1'b1;
                    state_nxt          = S_BRK_WAIT;
                end
            end

            S_BRK_WAIT: begin
                if (double_break_done)
                    state_nxt = S_FLUSH;
            end

            S_FLUSH: begin
                if (!uart_rx_fifo_empty)
                    uart_rx_fifo_rd_en = 1'b1;
                else
                    state_nxt = S_DONE;
            end

            S_DONE: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_updi_cs_access.sv
// Directed self-checking bench for updi_cs_access with a behavioural PHY FIFO/break model.
module tb_updi_cs_access;

    logic       clk = 1'b0;
    logic       rst;
    logic       req, req_store;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       busy, done;
    logic [7:0] rdata;
    logic [1:0] err_code;
    logic [7:0] uart_tx_fifo_data;
    logic       uart_tx_fifo_wr_en;
    logic       uart_tx_fifo_full;
    logic [7:0] rx_head = 8'h00;
    logic       uart_rx_fifo_rd_en;
    logic       rx_empty = 1'b1;
    logic       rx_error;
    logic       double_break_start;
    logic       brk_busy = 1'b0;
    logic       brk_done = 1'b0;

    int n_asserts = 0;
    int n_fail    = 0;

    updi_cs_access #(.TIMEOUT_CLK(50), .SYNCH_BYTE(8'h55)) dut (
        .clk                (clk),
        .rst                (rst),
        .req                (req),
        .req_store          (req_store),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .busy               (busy),
        .done               (done),
        .rdata              (rdata),
        .err_code           (err_code),
        .uart_tx_fifo_data  (uart_tx_fifo_data),
        .uart_tx_fifo_wr_en (uart_tx_fifo_wr_en),
        .uart_tx_fifo_full  (uart_tx_fifo_full),
        .uart_rx_fifo_data  (rx_head),
        .uart_rx_fifo_rd_en (uart_rx_fifo_rd_en),
        .uart_rx_fifo_empty (rx_empty),
        .rx_error           (rx_error),
        .double_break_start (double_break_start),
        .double_break_busy  (brk_busy),
        .double_break_done  (brk_done)
    );

    always #5 clk = ~clk;

    // PHY model: TX log, preloaded RX queue, break engine, event counters.
    logic [7:0] txlog[$];
    logic [7:0] rxq[$];
    int cyc = 0, pops = 0, starts = 0, brk_dones = 0, dones = 0;
    int last_pop_cyc = 0, start_cyc = 0, push_while_full = 0, brk_cnt = 0;

    always @(posedge clk) begin
        cyc++;
        if (uart_tx_fifo_wr_en) begin
            txlog.push_back(uart_tx_fifo_data);
            if (uart_tx_fifo_full) push_while_full++;
        end
        if (uart_rx_fifo_rd_en && rxq.size() > 0) begin
            void'(rxq.pop_front());
            pops++;
            last_pop_cyc = cyc;
        end
        if (double_break_start) begin
            starts++;
            start_cyc = cyc;
        end
        if (brk_done) brk_dones++;
        if (done) dones++;
        if (double_break_start) brk_cnt = 4;
        else if (brk_cnt != 0) brk_cnt--;
        brk_busy <= (brk_cnt != 0);
        brk_done <= (brk_cnt == 1);
        rx_empty <= (rxq.size() == 0);
        rx_head  <= (rxq.size() > 0) ? rxq[0] : 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge, away from the sampling edge.
    task automatic load_rx(input logic [7:0] b);
        rxq.push_back(b);
        rx_empty = 1'b0;
        rx_head  = rxq[0];
    endtask

    task automatic clear_rx();
        rxq.delete();
        rx_empty = 1'b1;
        rx_head  = 8'h00;
    endtask

    task automatic start_req(input logic st, input logic [3:0] a, input logic [7:0] wd);
        req       = 1'b1;
        req_store = st;
        req_addr  = a;
        req_wdata = wd;
        @(negedge clk);
        req = 1'b0;
    endtask

    // Returns negedges waited after start_req; done/rdata/err sampled while done is high.
    task automatic wait_done(input int max, input string tag, output int ncyc,
                             output logic [7:0] rd, output logic [1:0] ec);
        ncyc = 0;
        while (!done && ncyc < max) begin
            @(negedge clk);
            ncyc++;
        end
        if (!done) check({tag, "_done_timeout"}, 32'd0, 32'd1);
        rd = rdata;
        ec = err_code;
    endtask

    int         n, p0, s0, b0, d0;
    logic [7:0] rd;
    logic [1:0] ec;

    initial begin
        rst = 1'b1; req = 1'b0; req_store = 1'b0; req_addr = 4'h0; req_wdata = 8'h00;
        uart_tx_fifo_full = 1'b0; rx_error = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rdata", rdata, 8'h00);
        check("rst_err", err_code, 2'd0);
        check("rst_wr_en", uart_tx_fifo_wr_en, 1'b0);
        check("rst_rd_en", uart_rx_fifo_rd_en, 1'b0);
        check("rst_brk", double_break_start, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // LDCS addr 0: TX 2 + ECHO 2 + RESP 1 cycles, done seen 5 negedges after start_req.
        txlog.delete(); p0 = pops; d0 = dones;
        load_rx(8'h55); load_rx(8'h80); load_rx(8'h30);
        start_req(1'b0, 4'h0, 8'h00);
        wait_done(40, "ld", n, rd, ec);
        check("ld_latency", n, 5);
        check("ld_rdata", rd, 8'h30);
        check("ld_err", ec, 2'd0);
        check("ld_tx_cnt", txlog.size(), 2);
        check("ld_tx0", txlog[0], 8'h55);
        check("ld_tx1", txlog[1], 8'h80);
        check("ld_pops", pops - p0, 3);
        @(negedge clk);
        check("ld_done_pulse", dones - d0, 1);
        check("ld_idle", busy, 1'b0);

        // STCS addr 3 data 08: no response wait, extra byte stays in RX.
        txlog.delete(); p0 = pops;
        load_rx(8'h55); load_rx(8'hC3); load_rx(8'h08); load_rx(8'hEE);
        start_req(1'b1, 4'h3, 8'h08);
        wait_done(40, "st", n, rd, ec);
        check("st_latency", n, 6);
        check("st_err", ec, 2'd0);
        check("st_rdata_kept", rd, 8'h30);
        check("st_tx_cnt", txlog.size(), 3);
        check("st_tx0", txlog[0], 8'h55);
        check("st_tx1", txlog[1], 8'hC3);
        check("st_tx2", txlog[2], 8'h08);
        check("st_pops", pops - p0, 3);
        check("st_rx_left", rxq.size(), 1);
        @(negedge clk);
        clear_rx();

        // TX FIFO full for 10 cycles from the start of a store.
        txlog.delete(); push_while_full = 0;
        load_rx(8'h55); load_rx(8'hC5); load_rx(8'hA7);
        uart_tx_fifo_full = 1'b1;
        start_req(1'b1, 4'h5, 8'hA7);
        repeat (9) @(negedge clk);
        check("full_no_push", txlog.size(), 0);
        check("full_busy", busy, 1'b1);
        uart_tx_fifo_full = 1'b0;
        wait_done(40, "full", n, rd, ec);
        check("full_err", ec, 2'd0);
        check("full_tx_cnt", txlog.size(), 3);
        check("full_tx0", txlog[0], 8'h55);
        check("full_tx1", txlog[1], 8'hC5);
        check("full_tx2", txlog[2], 8'hA7);
        check("full_violation", push_while_full, 0);
        @(negedge clk);

        // LDCS with no response: 50 empty RESP cycles, break start on the cycle after.
        s0 = starts; b0 = brk_dones;
        load_rx(8'h55); load_rx(8'h80);
        start_req(1'b0, 4'h0, 8'h00);
        wait_done(200, "tmo", n, rd, ec);
        check("tmo_err", ec, 2'd1);
        check("tmo_starts", starts - s0, 1);
        check("tmo_brk_done_before", brk_dones - b0, 1);
        check("tmo_cycles", start_cyc - last_pop_cyc, 51);
        check("tmo_rx_empty", rx_empty, 1'b1);
        @(negedge clk);

        // Second echo corrupted (81 instead of 80), followed by three more bytes.
        s0 = starts; p0 = pops;
        load_rx(8'h55); load_rx(8'h81); load_rx(8'hA5); load_rx(8'h3C); load_rx(8'hC3);
        start_req(1'b0, 4'h0, 8'h00);
        wait_done(100, "mm", n, rd, ec);
`ifdef UPDI_ECHO_CHECK_EN
        check("mm_err", ec, 2'd3);
        check("mm_starts", starts - s0, 1);
        check("mm_pops", pops - p0, 5);
        check("mm_rx_empty", rxq.size(), 0);
`else
        check("mm_err", ec, 2'd0);
        check("mm_rdata", rd, 8'hA5);
        check("mm_starts", starts - s0, 0);
        check("mm_rx_left", rxq.size(), 2);
`endif
        @(negedge clk);
        clear_rx();

        // rx_error while waiting for the load response.
        s0 = starts; p0 = pops;
        load_rx(8'h55); load_rx(8'h80);
        start_req(1'b0, 4'h0, 8'h00);
        n = 0;
        while (pops - p0 < 2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rxe_echoes", pops - p0, 2);
        rx_error = 1'b1;
        @(negedge clk);
        rx_error = 1'b0;
        wait_done(100, "rxe", n, rd, ec);
        check("rxe_err", ec, 2'd2);
        check("rxe_starts", starts - s0, 1);
        @(negedge clk);

        // Asynchronous reset in the middle of TX.
        load_rx(8'h55); load_rx(8'hC3); load_rx(8'h08);
        start_req(1'b1, 4'h3, 8'h08);
        check("rst_pre_wr_en", uart_tx_fifo_wr_en, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_wr_en", uart_tx_fifo_wr_en, 1'b0);
        check("arst_err", err_code, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_rx();
        @(negedge clk);
        check("arst_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/updi_cs_access.md
Name: updi_cs_access

Overview:
- Link-layer sequencer directly upstream of the UPDI PHY.
- Converts single control/status register access requests (LDCS/STCS) into UPDI byte streams: SYNCH, opcode, and optional data byte.
- Pushes these bytes into the PHY TX FIFO. Pops and discards the single-wire echo of each transmitted byte from the PHY RX FIFO, then captures the target response for loads.
- On any link error, issues a double break through the PHY and flushes the RX FIFO before reporting.

Parameters:
- TIMEOUT_CLK, 200000: clk cycles allowed between RX bytes (echo or response) before declaring timeout.
- SYNCH_BYTE, 8'h55: synchronisation character sent at start of every access.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- req  input  1  start access; sampled only in IDLE
- req_store  input  1  1 = STCS, 0 = LDCS; sampled with req
- req_addr  input  4  CS register address; sampled with req
- req_wdata  input  8  store data; sampled with req
- busy  output  1  access in progress (not IDLE)
- done  output  1  one-cycle pulse at completion (success or error)
- rdata  output  8  LDCS result; valid from done until next accepted req
- err_code  output  2  0 none, 1 timeout, 2 rx_error, 3 echo mismatch; valid with done
- uart_tx_fifo_data  output  8  byte to PHY TX FIFO
- uart_tx_fifo_wr_en  output  1  push strobe
- uart_tx_fifo_full  input  1  PHY TX FIFO full
- uart_rx_fifo_data  input  8  show-ahead RX head; valid while !empty
- uart_rx_fifo_rd_en  output  1  pop strobe
- uart_rx_fifo_empty  input  1  PHY RX FIFO empty
- rx_error  input  1  PHY parity/framing error flag
- double_break_start  output  1  one-cycle break request
- double_break_busy  input  1  break in progress
- double_break_done  input  1  break-complete pulse

Behaviour:
- Reset: state IDLE; busy=0, done=0, rdata=8'h00, err_code=0, all strobes 0, counters 0.
- Opcode: LDCS = {4'h8, addr}, STCS = {4'hC, addr}.
- Byte count n = 3 for store, 2 for load.
- IDLE: on req=1, latch the request fields, clear err_code, go to TX. Transition takes 1 cycle.
- TX: each cycle with !uart_tx_fifo_full, assert wr_en with the next byte: SYNCH, opcode, then wdata (store only). A full FIFO stalls without a push. After byte n, go to ECHO with echo_cnt=n.
- ECHO: each cycle with !empty, assert rd_en, compare head against the expected byte (in send order), and decrement echo_cnt.
  - echo_cnt reaching 0: load goes to RESP; store goes to DONE.
- RESP: first cycle with !empty, assert rd_en, latch head into rdata, go to DONE.
- Timeout counter:
  - Cleared on entering ECHO and on each pop.
  - Increments in ECHO/RESP while empty.
  - Reaching TIMEOUT_CLK gives err_code=1 and goes to BREAK.
- rx_error=1 in ECHO/RESP gives err_code=2 and goes to BREAK.
- Error priority in the same cycle: rx_error > echo mismatch > timeout.
- BREAK: assert double_break_start for exactly 1 cycle, then wait for double_break_done. double_break_busy already high on entry means wait for done without re-asserting start.
- FLUSH: pop one byte per cycle while !empty; once empty, go to DONE.
- DONE: done=1 for one cycle, then IDLE. A req during DONE is ignored.
- Latency:
  - Load with immediate echoes/response and non-full TX: TX 2 cycles, ECHO 2, RESP 1, DONE 1.
  - The push never overlaps with the pop.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). Bytes already in PHY FIFOs are not this block's concern.
- Store issues no response wait: UPDI returns no ACK for STCS.

Optional Feature:
- Macro UPDI_ECHO_CHECK_EN.
- Defined: echo bytes are compared against sent bytes; mismatch gives err_code=3 and BREAK.
- Undefined: echoes are popped and counted only; err_code 3 is never produced. Timeout and rx_error handling are unchanged.

Test Plan:
- LDCS addr 4'h0, PHY loopback echo + response 8'h30 → TX pushes 55,80; 2 echo pops; rdata=8'h30, err_code=0, done one cycle.
- STCS addr 4'h3 data 8'h08 → TX pushes 55,C3,08; 3 echo pops; no response wait; done with err_code=0.
- TX FIFO full held 10 cycles at start → no wr_en during full; bytes then pushed in order, none lost or duplicated.
- LDCS with response never arriving, TIMEOUT_CLK=50 → err_code=1 after 50 empty cycles; one double_break_start pulse; done follows double_break_done.
- Second echo returned as 8'h81 with UPDI_ECHO_CHECK_EN → err_code=3, break issued, 3 stale RX bytes flushed, RX empty at done. Without the macro → rdata from next byte, err_code=0.
- rx_error asserted during RESP and rst asserted mid-TX → err_code=2 path completes; rst immediately forces busy=0, done=0, wr_en=0.
